// File: rtl/axi_lite_cnn_ctrl_slave.sv
// AXI4-Lite register slave for the CNN accelerator: six-word register bank,
// start/done handshake with the accelerator and a level interrupt to the core.
module axi_lite_cnn_ctrl_slave #(
  parameter int ADDR_LSB = 5,
  parameter int LEN_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             awvalid,
  input  logic [31:0]      awaddr,
  input  logic [2:0]       awprot,
  output logic             awready,
  input  logic             wvalid,
  input  logic [31:0]      wdata,
  input  logic [3:0]       wstrb,
  output logic             wready,
  output logic             bvalid,
  output logic [1:0]       bresp,
  input  logic             bready,
  input  logic             arvalid,
  input  logic [31:0]      araddr,
  input  logic [2:0]       arprot,
  output logic             arready,
  output logic             rvalid,
  output logic [31:0]      rdata,
  output logic [1:0]       rresp,
  output logic             rlast,
  input  logic             rready,
  output logic             accel_start,
  output logic [31:0]      accel_src_addr,
  output logic [31:0]      accel_dst_addr,
  output logic [LEN_W-1:0] accel_len,
  input  logic             accel_done,
  output logic             irq
);

  localparam int IW = ADDR_LSB - 2;
  localparam logic [IW-1:0] IDX_CTRL    = IW'(0);
  localparam logic [IW-1:0] IDX_STATUS  = IW'(1);
  localparam logic [IW-1:0] IDX_SRC     = IW'(2);
  localparam logic [IW-1:0] IDX_DST     = IW'(3);
  localparam logic [IW-1:0] IDX_LEN     = IW'(4);
  localparam logic [IW-1:0] IDX_SCRATCH = IW'(5);
  localparam logic [1:0]    RESP_OKAY   = 2'b00;
  localparam logic [1:0]    RESP_SLVERR = 2'b10;

  typedef enum logic {W_IDLE, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_DATA} r_state_t;

  w_state_t w_state, w_state_next;
  r_state_t r_state, r_state_next;

  logic          live;
  logic          aw_got, w_got;
  logic [IW-1:0] aw_idx_q;
  logic [31:0]   wdata_q;
  logic [3:0]    wstrb_q;
  logic          aw_hs, w_hs, ar_hs, commit;
  logic [IW-1:0] wr_idx, rd_idx;
  logic [31:0]   wr_data, rd_val;
  logic [3:0]    wr_strb;

  logic              irq_en, busy, done;
  logic [31:0]       src, dst, scratch;
  logic [LEN_W-1:0]  len;

  logic unused_ok;
  assign unused_ok = ^{awprot, arprot, awaddr[31:ADDR_LSB], awaddr[1:0],
                       araddr[31:ADDR_LSB], araddr[1:0]};

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [3:0]  strb);
    logic [31:0] res;
    for (int b = 0; b < 4; b++)
      res[8*b +: 8] = strb[b] ? new_val[8*b +: 8] : old_val[8*b +: 8];
    return res;
  endfunction

  function automatic logic idx_ok(input logic [IW-1:0] idx);
    return idx <= IDX_SCRATCH;
  endfunction

  // Write channel: AW and W are captured independently; the later one commits.
  assign awready = live && (w_state == W_IDLE) && !aw_got;
  assign wready  = live && (w_state == W_IDLE) && !w_got;
  assign aw_hs   = awvalid && awready;
  assign w_hs    = wvalid && wready;
  assign commit  = (w_state == W_IDLE) && (aw_got || aw_hs) && (w_got || w_hs);
  assign wr_idx  = aw_got ? aw_idx_q : awaddr[ADDR_LSB-1:2];
  assign wr_data = w_got ? wdata_q : wdata;
  assign wr_strb = w_got ? wstrb_q : wstrb;

  always_comb begin
    w_state_next = w_state;
    bvalid       = 1'b0;
    case (w_state)
      W_IDLE: if (commit) w_state_next = W_RESP;
      W_RESP: begin
        bvalid = 1'b1;
        if (bready) w_state_next = W_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      w_state  <= W_IDLE;
      live     <= 1'b0;
      aw_got   <= 1'b0;
      w_got    <= 1'b0;
      aw_idx_q <= '0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
      bresp    <= RESP_OKAY;
    end else begin
      w_state <= w_state_next;
      live    <= 1'b1;
      if (commit) begin
        aw_got <= 1'b0;
        w_got  <= 1'b0;
        bresp  <= idx_ok(wr_idx) ? RESP_OKAY : RESP_SLVERR;
      end else begin
        if (aw_hs) begin
          aw_got   <= 1'b1;
          aw_idx_q <= awaddr[ADDR_LSB-1:2];
        end
        if (w_hs) begin
          w_got   <= 1'b1;
          wdata_q <= wdata;
          wstrb_q <= wstrb;
        end
      end
    end
  end

  // Register bank; an accelerator done pulse overrides a same-cycle W1C of done.
  always_ff @(posedge clk) begin
    if (!reset) begin
      irq_en      <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      src         <= '0;
      dst         <= '0;
      len         <= '0;
      scratch     <= '0;
      accel_start <= 1'b0;
    end else begin
      accel_start <= 1'b0;
      if (commit) begin
        case (wr_idx)
          IDX_CTRL: begin
            if (wr_strb[0]) irq_en <= wr_data[1];
            if (wr_strb[0] && wr_data[0] && !busy) begin
              accel_start <= 1'b1;
              busy        <= 1'b1;
              done        <= 1'b0;
            end
          end
          IDX_STATUS:  if (wr_strb[0] && wr_data[1]) done <= 1'b0;
          IDX_SRC:     src     <= merge_bytes(src, wr_data, wr_strb);
          IDX_DST:     dst     <= merge_bytes(dst, wr_data, wr_strb);
          IDX_LEN:     len     <= LEN_W'(merge_bytes(32'(len), wr_data, wr_strb));
          IDX_SCRATCH: scratch <= merge_bytes(scratch, wr_data, wr_strb);
          default: ;
        endcase
      end
      if (accel_done) begin
        busy <= 1'b0;
        done <= 1'b1;
      end
    end
  end

  assign accel_src_addr = src;
  assign accel_dst_addr = dst;
  assign accel_len      = len;
  assign irq            = done && irq_en;

  // Read channel: register value and response are sampled at the AR handshake.
  assign arready = live && (r_state == R_IDLE);
  assign ar_hs   = arvalid && arready;
  assign rd_idx  = araddr[ADDR_LSB-1:2];
  assign rlast   = rvalid;

  always_comb begin
    rd_val = '0;
    case (rd_idx)
      IDX_CTRL:    rd_val = {30'b0, irq_en, 1'b0};
      IDX_STATUS:  rd_val = {30'b0, done, busy};
      IDX_SRC:     rd_val = src;
      IDX_DST:     rd_val = dst;
      IDX_LEN:     rd_val = 32'(len);
      IDX_SCRATCH: rd_val = scratch;
      default:     rd_val = '0;
    endcase
  end

  always_comb begin
    r_state_next = r_state;
    rvalid       = 1'b0;
    case (r_state)
      R_IDLE: if (ar_hs) r_state_next = R_DATA;
      R_DATA: begin
        rvalid = 1'b1;
        if (rready) r_state_next = R_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= R_IDLE;
      rdata   <= '0;
      rresp   <= RESP_OKAY;
    end else begin
      r_state <= r_state_next;
      if (ar_hs) begin
        rdata <= rd_val;
        rresp <= idx_ok(rd_idx) ? RESP_OKAY : RESP_SLVERR;
      end
    end
  end

endmodule
